// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for the multicycle single-issue 32-bit datapath. It sequences
// fetch, decode, execute, memory access and writeback. It drives the PC, IR,
// register-file, ALU, memory and immediate-extender select lines. It also
// waits on a memory-ready handshake, with an optional timeout.
//
// Parameters:
//   OPW          opcode field width
//   MEM_TIMEOUT  max wait cycles on mem_ready before abort (0 = never abort)
//
// Optional build macro:
//   ILLEGAL_TRAP_EN  unknown opcodes enter a TRAP state, which only reset can
//                    leave. This also adds the illegal_op output port.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        synchronous active-low reset
//   opcode         IR[31:26], valid from DECODE onward
//   zero           ALU zero flag
//   mem_ready      memory completes the current read/write this cycle
//   pc_write       unconditional PC load enable
//   pc_write_cond  PC load when zero=1 (branch)
//   pc_src         00 ALU result, 01 ALUOut, 10 jump target
//   ir_write       IR load enable
//   mem_read       memory read request
//   mem_write      memory write request
//   i_or_d         0 address=PC, 1 address=ALUOut
//   reg_write      register file write enable
//   reg_dst        0 rt, 1 rd
//   mem_to_reg     0 ALUOut, 1 MDR
//   alu_src_a      0 PC, 1 register A
//   alu_src_b      00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   alu_op         00 add, 01 sub, 10 funct-decoded, 11 logical-imm
//   ext_signed     1 sign-extend, 0 zero-extend immediate
//   busy           high in every state except FETCH
//   timeout_err    one-cycle pulse on memory timeout abort
//   illegal_op     (ILLEGAL_TRAP_EN only) high while in TRAP
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic [1:0]     pc_src,
  output logic           ir_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           i_or_d,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           ext_signed,
  output logic           busy,
  output logic           timeout_err
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic           illegal_op
`endif
);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  // The wait counter only has to reach MEM_TIMEOUT-1. The abort is decided
  // in the MEM_TIMEOUT-th consecutive wait cycle.
  localparam bit          TIMEOUT_ON = (MEM_TIMEOUT > 0);
  localparam int          CW         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_LW_WB, S_EXEC_R,
    S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_reg, wait_next;
  // The abort cycle is spent in FETCH with this flag set. Every enable is
  // suppressed during that cycle, and the fetch is retried on the next cycle.
  logic          timeout_reg, timeout_next;
  logic          mem_waiting;
  logic          imm_signed;

  // The zero flag gates pc_write_cond in the datapath and is not needed here.
  logic unused_inputs;
  assign unused_inputs = zero;

  assign mem_waiting = !mem_ready && !timeout_reg &&
                       (state_reg inside {S_FETCH, S_MEMRD, S_MEMWR});
  // ADDI sign-extends. ANDI/ORI zero-extend and use the logical-imm ALU op.
  assign imm_signed  = (opcode == OP_ADDI);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= S_FETCH;
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = '0;
    timeout_next = 1'b0;
    case (state_reg)
      S_FETCH:  if (!timeout_reg && mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             state_next = S_MEMADR;
          OP_R:                     state_next = S_EXEC_R;
          OP_BEQ:                   state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
          OP_J:                     state_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:                  state_next = S_TRAP;
`else
          default:                  state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_LW_WB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC_R: state_next = S_R_WB;
      S_EXEC_I: state_next = S_I_WB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_FETCH;
    endcase

    // A mem_ready that arrives in the limit cycle keeps mem_waiting low, so
    // the normal transition above wins.
    if (mem_waiting && TIMEOUT_ON) begin
      if (wait_reg == LIMIT) begin
        state_next   = S_FETCH;
        timeout_next = 1'b1;
      end else begin
        wait_next = wait_reg + 1'b1;
      end
    end
  end

  // Moore decode from the state register. pc_write in FETCH follows
  // mem_ready, and the request lines stay up through wait cycles.
  // Outputs are forced low whenever reset_n is low.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    ext_signed    = 1'b0;
    busy          = 1'b0;
    timeout_err   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    if (reset_n) begin
      if (timeout_reg) begin
        timeout_err = 1'b1;
      end else begin
        busy = (state_reg != S_FETCH);
        case (state_reg)
          S_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = mem_ready;
          end
          S_DECODE: begin
            alu_src_b  = 2'b11;
            ext_signed = 1'b1;
          end
          S_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            ext_signed = 1'b1;
          end
          S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
          end
          S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
          end
          S_LW_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
          end
          S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
          end
          S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
          end
          S_EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            ext_signed = imm_signed;
            alu_op     = imm_signed ? 2'b00 : 2'b11;
          end
          S_I_WB: begin
            reg_write  = 1'b1;
            ext_signed = imm_signed;
            alu_op     = imm_signed ? 2'b00 : 2'b11;
          end
          S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
          end
          S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
          S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
            illegal_op = 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control, built with MEM_TIMEOUT=4. Each step
// applies the inputs for one cycle. It then compares every control output
// against a hand-written per-state table.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_signed;
    logic       busy;
    logic       timeout_err;
  } ctl_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_signed, busy, timeout_err;
  logic [1:0] pc_src, alu_src_b, alu_op;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int vectors = 0;
  int miscompares = 0;

  ctl_t obs;
  assign obs = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
                i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_op, ext_signed, busy, timeout_err};

  always #5 clock = ~clock;

  multicycle_control #(.OPW(6), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_signed(ext_signed),
    .busy(busy), .timeout_err(timeout_err)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  // Expected outputs for a named state, taken directly from the state table.
  function automatic ctl_t ex(input string st, input logic rdy);
    ctl_t c;
    c = '0;
    if (st == "FETCH") begin
      c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = rdy;
    end else if (st == "ABORT") begin
      c.timeout_err = 1;
    end else if (st == "DECODE") begin
      c.busy = 1; c.alu_src_b = 2'b11; c.ext_signed = 1;
    end else if (st == "MEMADR") begin
      c.busy = 1; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_signed = 1;
    end else if (st == "MEMRD") begin
      c.busy = 1; c.mem_read = 1; c.i_or_d = 1;
    end else if (st == "MEMWR") begin
      c.busy = 1; c.mem_write = 1; c.i_or_d = 1;
    end else if (st == "LW_WB") begin
      c.busy = 1; c.reg_write = 1; c.mem_to_reg = 1;
    end else if (st == "EXEC_R") begin
      c.busy = 1; c.alu_src_a = 1; c.alu_op = 2'b10;
    end else if (st == "R_WB") begin
      c.busy = 1; c.reg_write = 1; c.reg_dst = 1;
    end else if (st == "EXEC_ADDI") begin
      c.busy = 1; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_signed = 1;
    end else if (st == "I_WB_ADDI") begin
      c.busy = 1; c.reg_write = 1; c.ext_signed = 1;
    end else if (st == "EXEC_LOGI") begin
      c.busy = 1; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
    end else if (st == "I_WB_LOGI") begin
      c.busy = 1; c.reg_write = 1; c.alu_op = 2'b11;
    end else if (st == "BRANCH") begin
      c.busy = 1; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_src = 2'b01;
    end else if (st == "JUMP") begin
      c.busy = 1; c.pc_write = 1; c.pc_src = 2'b10;
    end else if (st == "TRAP") begin
      c.busy = 1;
    end
    return c;
  endfunction

  // Drive one cycle's inputs at the falling edge, then check the outputs.
  task automatic step(input string tag, input logic rst_n, input logic rdy,
                      input logic [5:0] op, input string st);
    ctl_t e;
    @(negedge clock);
    reset_n   = rst_n;
    mem_ready = rdy;
    opcode    = op;
    #1;
    e = ex(st, rdy);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s (%s): got %h want %h", tag, st, obs, e);
    end
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, ANDI = 6'b001100,
                         ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;

  initial begin
    // Reset held for two edges with mem_ready=1: everything low.
    step("reset0", 0, 1, R, "ZERO");
    step("reset1", 0, 1, R, "ZERO");
    step("fetch_wait", 1, 0, R, "FETCH");
    // ADDI
    step("addi_f", 1, 1, ADDI, "FETCH");
    step("addi_d", 1, 1, ADDI, "DECODE");
    step("addi_x", 1, 1, ADDI, "EXEC_ADDI");
    step("addi_wb", 1, 1, ADDI, "I_WB_ADDI");
    // ORI
    step("ori_f", 1, 1, ORI, "FETCH");
    step("ori_d", 1, 1, ORI, "DECODE");
    step("ori_x", 1, 1, ORI, "EXEC_LOGI");
    step("ori_wb", 1, 1, ORI, "I_WB_LOGI");
    // ANDI
    step("andi_f", 1, 1, ANDI, "FETCH");
    step("andi_d", 1, 1, ANDI, "DECODE");
    step("andi_x", 1, 1, ANDI, "EXEC_LOGI");
    step("andi_wb", 1, 1, ANDI, "I_WB_LOGI");
    // LW with three wait cycles in MEMRD
    step("lw_f", 1, 1, LW, "FETCH");
    step("lw_d", 1, 1, LW, "DECODE");
    step("lw_a", 1, 1, LW, "MEMADR");
    step("lw_w1", 1, 0, LW, "MEMRD");
    step("lw_w2", 1, 0, LW, "MEMRD");
    step("lw_w3", 1, 0, LW, "MEMRD");
    step("lw_rd", 1, 1, LW, "MEMRD");
    step("lw_wb", 1, 1, LW, "LW_WB");
    // BEQ
    step("beq_f", 1, 1, BEQ, "FETCH");
    step("beq_d", 1, 1, BEQ, "DECODE");
    step("beq_b", 1, 1, BEQ, "BRANCH");
    // R-type
    step("r_f", 1, 1, R, "FETCH");
    step("r_d", 1, 1, R, "DECODE");
    step("r_x", 1, 1, R, "EXEC_R");
    step("r_wb", 1, 1, R, "R_WB");
    // J
    step("j_f", 1, 1, J, "FETCH");
    step("j_d", 1, 1, J, "DECODE");
    step("j_j", 1, 1, J, "JUMP");
    // SW timeout: four wait cycles, abort pulse, then a clean fetch
    step("swto_f", 1, 1, SW, "FETCH");
    step("swto_d", 1, 1, SW, "DECODE");
    step("swto_a", 1, 1, SW, "MEMADR");
    step("swto_w1", 1, 0, SW, "MEMWR");
    step("swto_w2", 1, 0, SW, "MEMWR");
    step("swto_w3", 1, 0, SW, "MEMWR");
    step("swto_w4", 1, 0, SW, "MEMWR");
    step("swto_abort", 1, 1, SW, "ABORT");
    step("swto_refetch", 1, 1, SW, "FETCH");
    // SW with mem_ready arriving in the limit cycle: no error
    step("sw_d", 1, 1, SW, "DECODE");
    step("sw_a", 1, 1, SW, "MEMADR");
    step("sw_w1", 1, 0, SW, "MEMWR");
    step("sw_w2", 1, 0, SW, "MEMWR");
    step("sw_w3", 1, 0, SW, "MEMWR");
    step("sw_lim_ready", 1, 1, SW, "MEMWR");
    step("sw_no_err", 1, 1, LW, "FETCH");
    // Reset in the middle of a pending LW read
    step("rst_d", 1, 1, LW, "DECODE");
    step("rst_a", 1, 1, LW, "MEMADR");
    step("rst_w", 1, 0, LW, "MEMRD");
    step("rst_mid", 0, 0, LW, "ZERO");
    step("rst_after", 1, 0, BAD, "FETCH");
    // Unknown opcode
    step("bad_f", 1, 1, BAD, "FETCH");
    step("bad_d", 1, 1, BAD, "DECODE");
`ifdef ILLEGAL_TRAP_EN
    step("trap0", 1, 1, BAD, "TRAP");
    vectors++;
    assert (illegal_op === 1'b1) else begin
      miscompares++;
      $error("FAIL illegal_op0: got %b want 1", illegal_op);
    end
    step("trap1", 1, 1, R, "TRAP");
    vectors++;
    assert (illegal_op === 1'b1) else begin
      miscompares++;
      $error("FAIL illegal_op1: got %b want 1", illegal_op);
    end
    step("trap_rst", 0, 1, R, "ZERO");
    step("trap_out", 1, 0, R, "FETCH");
    vectors++;
    assert (illegal_op === 1'b0) else begin
      miscompares++;
      $error("FAIL illegal_op_clr: got %b want 0", illegal_op);
    end
`else
    step("bad_nop", 1, 1, R, "FETCH");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
